// File: rtl/cic_ctrl_pkg.sv
// Shared types and decimation lookup for the CIC conversion controller.
package cic_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StClear  = 2'd1,
      StSettle = 2'd2,
      StRun    = 2'd3
   } state_e;

   localparam int unsigned DefaultNumbits = 25;
   localparam int unsigned DecCntWidth    = 8;

   localparam logic [1:0] DecSel32  = 2'd0;
   localparam logic [1:0] DecSel64  = 2'd1;
   localparam logic [1:0] DecSel128 = 2'd2;
   localparam logic [1:0] DecSel256 = 2'd3;

   function automatic logic [8:0] dec_len(input logic [1:0] sel);
      unique case (sel)
         DecSel32:  return 9'd32;
         DecSel64:  return 9'd64;
         DecSel128: return 9'd128;
         DecSel256: return 9'd256;
      endcase
   endfunction

   // Terminal count for the modulo counter (D-1).
   function automatic logic [DecCntWidth-1:0] dec_last(input logic [1:0] sel);
      return DecCntWidth'(dec_len(sel) - 9'd1);
   endfunction

endpackage

// File: rtl/cic_dec_counter.sv
// Programmable modulo counter: counts 0..last, wraps to 0 and strobes wrap at last.
module cic_dec_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] last,
   output logic             wrap
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = (count_q == last) ? '0 : count_q + WIDTH'(1);
      end
   end

   assign wrap = enable && !clear && (count_q == last);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/cic_conv_ctrl.sv
// Conversion sequencer for a CIC decimator: clear, settle, dump timing and result handoff.
module cic_conv_ctrl
   import cic_ctrl_pkg::*;
#(
   parameter int unsigned NUMBITS      = DefaultNumbits,
   parameter int unsigned SETTLE_COUNT = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic               continuous,
   input  logic [1:0]         dec_sel,
   output logic               cic_clear,
   output logic               cic_dump,
   input  logic [NUMBITS-1:0] cic_data,
   output logic [NUMBITS-1:0] data,
   output logic               data_valid,
   input  logic               data_ready,
   output logic               busy,
   output logic               overrun
);

   localparam logic [15:0] SettleLast = (SETTLE_COUNT == 0) ? 16'd0 : 16'(SETTLE_COUNT - 1);

   state_e               state_q, state_d;
   logic [1:0]           dec_q, dec_d;
   logic                 cont_q, cont_d;
   logic [15:0]          settle_q, settle_d;
   logic                 dump_q, dump_d;
   logic [NUMBITS-1:0]   data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ovr_q, ovr_d;
   logic                 launch;
   logic                 capture;
   logic                 cnt_clear;
   logic                 cnt_en;
   logic                 wrap;

   assign cnt_clear = (state_q == StIdle) || (state_q == StClear);
   assign cnt_en    = (state_q == StSettle) || (state_q == StRun);

   cic_dec_counter #(
      .WIDTH (DecCntWidth)
   ) u_dec_counter (
      .clk    (clk),
      .reset  (reset),
      .clear  (cnt_clear),
      .enable (cnt_en),
      .last   (dec_last(dec_q)),
      .wrap   (wrap)
   );

   // Only RUN-state dumps lead to a capture; a stop in the capture cycle suppresses it.
   assign dump_d  = wrap && (state_q == StRun);
   assign capture = dump_q && (state_q == StRun) && !stop;

   always_comb begin
      state_d  = state_q;
      dec_d    = dec_q;
      cont_d   = cont_q;
      settle_d = settle_q;
      launch   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start && !stop) begin
               state_d = StClear;
               dec_d   = dec_sel;
               cont_d  = continuous;
               launch  = 1'b1;
            end
         end
         StClear: begin
            settle_d = '0;
            if (stop) begin
               state_d = StIdle;
            end else if (SETTLE_COUNT == 0) begin
               state_d = StRun;
            end else begin
               state_d = StSettle;
            end
         end
         StSettle: begin
            if (stop) begin
               state_d = StIdle;
            end else if (wrap) begin
               if (settle_q == SettleLast) begin
                  state_d = StRun;
               end else begin
                  settle_d = settle_q + 16'd1;
               end
            end
         end
         StRun: begin
            if (stop || (capture && !cont_q)) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output holding register: a new word is dropped only if the old one is still unaccepted.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (launch) begin
         ovr_d = 1'b0;
      end
      if (capture) begin
         if (!valid_q || data_ready) begin
            data_d  = cic_data;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && data_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         dec_q    <= '0;
         cont_q   <= 1'b0;
         settle_q <= '0;
         dump_q   <= 1'b0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         dec_q    <= dec_d;
         cont_q   <= cont_d;
         settle_q <= settle_d;
         dump_q   <= dump_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         ovr_q    <= ovr_d;
      end
   end

   assign cic_clear  = (state_q == StClear);
   assign cic_dump   = wrap;
   assign busy       = (state_q != StIdle);
   assign data       = data_q;
   assign data_valid = valid_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_cic_conv_ctrl.sv
// Scenario bench for cic_conv_ctrl; expected words queued at capture time, checked on handoff.
module tb_cic_conv_ctrl;

   localparam int N = 25;

   logic         clk;
   logic         reset;
   logic         start;
   logic         stop;
   logic         continuous;
   logic [1:0]   dec_sel;
   logic         cic_clear;
   logic         cic_dump;
   logic [N-1:0] cic_data;
   logic [N-1:0] data;
   logic         data_valid;
   logic         data_ready;
   logic         busy;
   logic         overrun;

   int           cyc;
   int           checks;
   int           errors;
   logic [N-1:0] sb[$];
   logic [N-1:0] exp_word;

   cic_conv_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .continuous (continuous),
      .dec_sel    (dec_sel),
      .cic_clear  (cic_clear),
      .cic_dump   (cic_dump),
      .cic_data   (cic_data),
      .data       (data),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .busy       (busy),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [N-1:0] pat(input int c);
      logic [31:0] v;
      v = 32'(c) * 32'd40503 + 32'd12345;
      return v[N-1:0];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      cic_data = pat(cyc);
   endtask

   // Start pulse in cycle 0; returns positioned in cycle 1.
   task automatic begin_conv(input logic [1:0] ds, input logic cont);
      cyc = 0;
      dec_sel = ds;
      continuous = cont;
      start = 1'b1;
      cic_data = pat(0);
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", data_valid); end
      checks++; if (data !== '0) begin errors++; $display("FAIL rst_data got=%h exp=0", data); end
      checks++; if (cic_clear !== 1'b0) begin errors++; $display("FAIL rst_clear got=%b exp=0", cic_clear); end
      checks++; if (cic_dump !== 1'b0) begin errors++; $display("FAIL rst_dump got=%b exp=0", cic_dump); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_ovr got=%b exp=0", overrun); end
   endtask

   // D=32 single shot; dec_sel/continuous changes and a start while busy must be ignored.
   task automatic test_single_shot();
      logic ed, ev, eb;
      data_ready = 1'b1;
      begin_conv(2'd0, 1'b0);
      while (cyc <= 140) begin
         if (cyc == 40) begin dec_sel = 2'd3; continuous = 1'b1; end
         start = (cyc == 70);
         if (cyc == 130) sb.push_back(pat(cyc));
         ed = (cyc == 33) || (cyc == 65) || (cyc == 97) || (cyc == 129);
         ev = (cyc == 131);
         eb = (cyc <= 130);
         checks++; if (cic_clear !== (cyc == 1)) begin errors++;
            $display("FAIL ss_clear cyc=%0d got=%b exp=%b", cyc, cic_clear, cyc == 1); end
         checks++; if (cic_dump !== ed) begin errors++;
            $display("FAIL ss_dump cyc=%0d got=%b exp=%b", cyc, cic_dump, ed); end
         checks++; if (data_valid !== ev) begin errors++;
            $display("FAIL ss_valid cyc=%0d got=%b exp=%b", cyc, data_valid, ev); end
         checks++; if (busy !== eb) begin errors++;
            $display("FAIL ss_busy cyc=%0d got=%b exp=%b", cyc, busy, eb); end
         if (data_valid && data_ready) begin
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL ss_sb_empty cyc=%0d got=%h exp=none", cyc, data); end
            else begin
               exp_word = sb.pop_front();
               if (data !== exp_word) begin errors++;
                  $display("FAIL ss_data cyc=%0d got=%h exp=%h", cyc, data, exp_word); end
            end
         end
         step();
      end
      start = 1'b0;
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL ss_sb_left got=%0d exp=0", sb.size()); end
   endtask

   // D=256 free-running with ready=1, stopped away from a capture.
   task automatic test_continuous_256();
      logic ed, ev, eb;
      data_ready = 1'b1;
      begin_conv(2'd3, 1'b1);
      while (cyc <= 1640) begin
         stop = (cyc == 1639);
         if (cyc >= 1026 && cyc < 1639 && ((cyc - 1026) % 256) == 0) sb.push_back(pat(cyc));
         ed = (cyc >= 257) && (cyc <= 1639) && (((cyc - 257) % 256) == 0);
         ev = (cyc >= 1027) && (cyc < 1640) && (((cyc - 1027) % 256) == 0);
         eb = (cyc <= 1639);
         checks++; if (cic_dump !== ed) begin errors++;
            $display("FAIL c256_dump cyc=%0d got=%b exp=%b", cyc, cic_dump, ed); end
         checks++; if (data_valid !== ev) begin errors++;
            $display("FAIL c256_valid cyc=%0d got=%b exp=%b", cyc, data_valid, ev); end
         checks++; if (busy !== eb) begin errors++;
            $display("FAIL c256_busy cyc=%0d got=%b exp=%b", cyc, busy, eb); end
         checks++; if (overrun !== 1'b0) begin errors++;
            $display("FAIL c256_ovr cyc=%0d got=%b exp=0", cyc, overrun); end
         if (data_valid && data_ready) begin
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL c256_sb_empty cyc=%0d got=%h exp=none", cyc, data); end
            else begin
               exp_word = sb.pop_front();
               if (data !== exp_word) begin errors++;
                  $display("FAIL c256_data cyc=%0d got=%h exp=%h", cyc, data, exp_word); end
            end
         end
         step();
      end
      stop = 1'b0;
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL c256_sb_left got=%0d exp=0", sb.size()); end
   endtask

   // D=32 free-running with ready low: first word held, later captures dropped, overrun sticky.
   task automatic test_overrun();
      logic ev, eo, eb;
      data_ready = 1'b0;
      begin_conv(2'd0, 1'b1);
      while (cyc <= 241) begin
         if (cyc == 200) data_ready = 1'b1;
         stop = (cyc == 240);
         if (cyc == 130 || cyc == 226) sb.push_back(pat(cyc));
         ev = ((cyc >= 131) && (cyc <= 200)) || (cyc == 227);
         eo = (cyc >= 163);
         eb = (cyc <= 240);
         checks++; if (data_valid !== ev) begin errors++;
            $display("FAIL ovr_valid cyc=%0d got=%b exp=%b", cyc, data_valid, ev); end
         checks++; if (overrun !== eo) begin errors++;
            $display("FAIL ovr_flag cyc=%0d got=%b exp=%b", cyc, overrun, eo); end
         checks++; if (busy !== eb) begin errors++;
            $display("FAIL ovr_busy cyc=%0d got=%b exp=%b", cyc, busy, eb); end
         if (cyc >= 131 && cyc <= 200) begin
            checks++; if (data !== pat(130)) begin errors++;
               $display("FAIL ovr_hold cyc=%0d got=%h exp=%h", cyc, data, pat(130)); end
         end
         if (data_valid && data_ready) begin
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL ovr_sb_empty cyc=%0d got=%h exp=none", cyc, data); end
            else begin
               exp_word = sb.pop_front();
               if (data !== exp_word) begin errors++;
                  $display("FAIL ovr_data cyc=%0d got=%h exp=%h", cyc, data, exp_word); end
            end
         end
         step();
      end
      stop = 1'b0;
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL ovr_sb_left got=%0d exp=0", sb.size()); end
      // A new start clears overrun; a stop in CLEAR returns to idle.
      begin_conv(2'd0, 1'b0);
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr got=%b exp=0", overrun); end
      checks++; if (cic_clear !== 1'b1) begin errors++; $display("FAIL clr_state got=%b exp=1", cic_clear); end
      stop = 1'b1;
      step();
      stop = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_stop_busy got=%b exp=0", busy); end
   endtask

   // Stop in cycle 50 of a D=32 conversion.
   task automatic test_stop();
      logic ed, eb;
      data_ready = 1'b1;
      begin_conv(2'd0, 1'b0);
      while (cyc <= 200) begin
         stop = (cyc == 50);
         ed = (cyc == 33);
         eb = (cyc <= 50);
         checks++; if (cic_dump !== ed) begin errors++;
            $display("FAIL stop_dump cyc=%0d got=%b exp=%b", cyc, cic_dump, ed); end
         checks++; if (busy !== eb) begin errors++;
            $display("FAIL stop_busy cyc=%0d got=%b exp=%b", cyc, busy, eb); end
         checks++; if (data_valid !== 1'b0) begin errors++;
            $display("FAIL stop_valid cyc=%0d got=%b exp=0", cyc, data_valid); end
         step();
      end
      stop = 1'b0;
   endtask

   // Stop on the edge of a due capture: capture discarded, pending word kept, no overrun.
   task automatic test_stop_capture();
      logic ev, eb;
      data_ready = 1'b0;
      begin_conv(2'd0, 1'b1);
      while (cyc <= 205) begin
         stop = (cyc == 162);
         if (cyc == 200) data_ready = 1'b1;
         if (cyc == 130) sb.push_back(pat(cyc));
         ev = (cyc >= 131) && (cyc <= 200);
         eb = (cyc <= 162);
         checks++; if (data_valid !== ev) begin errors++;
            $display("FAIL stc_valid cyc=%0d got=%b exp=%b", cyc, data_valid, ev); end
         checks++; if (busy !== eb) begin errors++;
            $display("FAIL stc_busy cyc=%0d got=%b exp=%b", cyc, busy, eb); end
         checks++; if (overrun !== 1'b0) begin errors++;
            $display("FAIL stc_ovr cyc=%0d got=%b exp=0", cyc, overrun); end
         if (data_valid && data_ready) begin
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL stc_sb_empty cyc=%0d got=%h exp=none", cyc, data); end
            else begin
               exp_word = sb.pop_front();
               if (data !== exp_word) begin errors++;
                  $display("FAIL stc_data cyc=%0d got=%h exp=%h", cyc, data, exp_word); end
            end
         end
         step();
      end
      stop = 1'b0;
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL stc_sb_left got=%0d exp=0", sb.size()); end
   endtask

   // Reset mid-RUN with a word pending, then a fresh conversion with full latency.
   task automatic test_reset_mid();
      logic ed, ev;
      data_ready = 1'b0;
      begin_conv(2'd0, 1'b1);
      while (cyc <= 140) begin
         ev = (cyc >= 131);
         checks++; if (data_valid !== ev) begin errors++;
            $display("FAIL rm_pre_valid cyc=%0d got=%b exp=%b", cyc, data_valid, ev); end
         step();
      end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got=%b exp=0", data_valid); end
      checks++; if (data !== '0) begin errors++; $display("FAIL rm_data got=%h exp=0", data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got=%b exp=0", busy); end
      checks++; if (cic_dump !== 1'b0) begin errors++; $display("FAIL rm_dump got=%b exp=0", cic_dump); end
      checks++; if (cic_clear !== 1'b0) begin errors++; $display("FAIL rm_clear got=%b exp=0", cic_clear); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rm_ovr got=%b exp=0", overrun); end
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
      data_ready = 1'b1;
      begin_conv(2'd0, 1'b0);
      while (cyc <= 135) begin
         if (cyc == 130) sb.push_back(pat(cyc));
         ed = (cyc == 33) || (cyc == 65) || (cyc == 97) || (cyc == 129);
         ev = (cyc == 131);
         checks++; if (cic_clear !== (cyc == 1)) begin errors++;
            $display("FAIL rm_new_clear cyc=%0d got=%b exp=%b", cyc, cic_clear, cyc == 1); end
         checks++; if (cic_dump !== ed) begin errors++;
            $display("FAIL rm_new_dump cyc=%0d got=%b exp=%b", cyc, cic_dump, ed); end
         checks++; if (data_valid !== ev) begin errors++;
            $display("FAIL rm_new_valid cyc=%0d got=%b exp=%b", cyc, data_valid, ev); end
         if (data_valid && data_ready) begin
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL rm_sb_empty cyc=%0d got=%h exp=none", cyc, data); end
            else begin
               exp_word = sb.pop_front();
               if (data !== exp_word) begin errors++;
                  $display("FAIL rm_data_new cyc=%0d got=%h exp=%h", cyc, data, exp_word); end
            end
         end
         step();
      end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL rm_sb_left got=%0d exp=0", sb.size()); end
   endtask

   // start and stop together in IDLE: stop wins.
   task automatic test_start_stop();
      start = 1'b1;
      stop = 1'b1;
      repeat (3) begin
         step();
         checks++; if (cic_clear !== 1'b0) begin errors++; $display("FAIL ss2_clear got=%b exp=0", cic_clear); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ss2_busy got=%b exp=0", busy); end
      end
      start = 1'b0;
      stop = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc = 0;
      reset = 1'b1;
      start = 1'b0;
      stop = 1'b0;
      continuous = 1'b0;
      dec_sel = 2'd0;
      cic_data = '0;
      data_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      reset = 1'b0;
      step();
      test_reset();
      test_start_stop();
      test_single_shot();
      test_continuous_256();
      test_overrun();
      test_stop();
      test_stop_capture();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
